// File: rtl/smbs_pkg.sv
// Shared definitions for the serial multi-bus frame router: FSM encoding and
// default geometry constants.
package smbs_pkg;

  localparam int unsigned DEF_NPORTS = 4;
  localparam int unsigned DEF_NLANES = 4;
  localparam int unsigned DEF_LSEL_W = 2;
  localparam int unsigned DEF_CNT_W  = 4;

  typedef enum logic [2:0] {
    StIdle,
    StPort,
    StLane,
    StCnt,
    StData,
    StDone
  } smbs_state_e;

endpackage

// File: rtl/smbs_field_shifter.sv
// Generic MSB-first field shift register with a bit counter. The value can also
// be decremented once fully loaded, which lets it double as a down-counter.
module smbs_field_shifter #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clear,
  input  logic         i_shift,
  input  logic         i_bit,
  input  logic         i_dec,
  output logic [W-1:0] o_value,
  output logic         o_last
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W-1:0]  r_value;
  logic [CW-1:0] r_cnt;

  // High while the bit being shifted in this cycle completes the field.
  assign o_last  = (r_cnt == CW'(W - 1));
  assign o_value = r_value;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (i_clear) begin
      r_value <= '0;
      r_cnt   <= '0;
    end else if (i_shift) begin
      r_value <= (r_value << 1) | W'(i_bit);
      r_cnt   <= r_cnt + CW'(1);
    end else if (i_dec) begin
      r_value <= r_value - W'(1);
    end
  end

endmodule

// File: rtl/smbs_frame_router.sv
// Parses start/mask/lane/length frames from a serial line and routes payload
// bits onto the selected lane of every masked port, all outputs registered.
module smbs_frame_router
  import smbs_pkg::*;
#(
  parameter int unsigned NPORTS = DEF_NPORTS,
  parameter int unsigned NLANES = DEF_NLANES,
  parameter int unsigned LSEL_W = DEF_LSEL_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     serIn,
  output logic [NPORTS*NLANES-1:0] L_output,
  output logic                     L_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  smbs_state_e r_state, w_state_d;

  logic [NPORTS-1:0]        w_mask;
  logic [LSEL_W-1:0]        w_lane;
  logic [CNT_W-1:0]         w_len;
  logic [CNT_W-1:0]         w_len_shift;
  logic                     w_mask_last, w_lane_last, w_len_last;
  logic                     w_clear, w_sh_mask, w_sh_lane, w_sh_len, w_dec_len;
  logic [NPORTS*NLANES-1:0] w_route;

  logic [NPORTS*NLANES-1:0] r_lout;
  logic                     r_valid, r_busy, r_done, r_err;

  smbs_field_shifter #(.W(NPORTS)) u_mask (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_shift (w_sh_mask),
    .i_bit   (serIn),
    .i_dec   (1'b0),
    .o_value (w_mask),
    .o_last  (w_mask_last)
  );

  smbs_field_shifter #(.W(LSEL_W)) u_lane (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_shift (w_sh_lane),
    .i_bit   (serIn),
    .i_dec   (1'b0),
    .o_value (w_lane),
    .o_last  (w_lane_last)
  );

  smbs_field_shifter #(.W(CNT_W)) u_len (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_clear),
    .i_shift (w_sh_len),
    .i_bit   (serIn),
    .i_dec   (w_dec_len),
    .o_value (w_len),
    .o_last  (w_len_last)
  );

  // Length as it will be once the current bit lands; decides DATA vs DONE.
  assign w_len_shift = (w_len << 1) | CNT_W'(serIn);

  always_comb begin
    w_state_d = r_state;
    w_clear   = 1'b0;
    w_sh_mask = 1'b0;
    w_sh_lane = 1'b0;
    w_sh_len  = 1'b0;
    w_dec_len = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_clear = 1'b1;
        if (!serIn) w_state_d = StPort;
      end
      StPort: begin
        w_sh_mask = 1'b1;
        if (w_mask_last) w_state_d = StLane;
      end
      StLane: begin
        w_sh_lane = 1'b1;
        if (w_lane_last) w_state_d = StCnt;
      end
      StCnt: begin
        w_sh_len = 1'b1;
        if (w_len_last) w_state_d = (w_len_shift == '0) ? StDone : StData;
      end
      StData: begin
        w_dec_len = 1'b1;
        if (w_len == CNT_W'(1)) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_route = '0;
    for (int p = 0; p < NPORTS; p++) begin
      for (int l = 0; l < NLANES; l++) begin
        w_route[p*NLANES+l] = w_mask[p] & (w_lane == LSEL_W'(l)) & serIn;
      end
    end
  end

  // Outputs reflect the state being left, so busy falls exactly as done pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_lout  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_lout  <= (r_state == StData) ? w_route : '0;
      r_valid <= (r_state == StData);
      r_busy  <= (r_state inside {StPort, StLane, StCnt, StData}) ||
                 ((r_state == StIdle) && !serIn);
      r_done  <= (r_state == StDone);
      r_err   <= (r_state == StDone) && (w_mask == '0);
    end
  end

  assign L_output = r_lout;
  assign L_valid  = r_valid;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_smbs_frame_router.sv
// Directed, table-driven bench for smbs_frame_router at default geometry.
module tb_smbs_frame_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serIn = 1'b1;
  logic [15:0] L_output;
  logic        L_valid, busy, done, err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       tag;
    logic        ser;
    logic [19:0] exp;
  } vec_t;

  vec_t q_vec[$];

  smbs_frame_router #(
    .NPORTS (4),
    .NLANES (4),
    .LSEL_W (2),
    .CNT_W  (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .serIn    (serIn),
    .L_output (L_output),
    .L_valid  (L_valid),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [19:0] exp);
    logic [19:0] act;
    act = {L_output, L_valid, busy, done, err};
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got lout=%h valid=%b busy=%b done=%b err=%b, want lout=%h valid=%b busy=%b done=%b err=%b",
               tag, act[19:4], act[3], act[2], act[1], act[0],
               exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input string tag, input logic ser, input logic [15:0] lout,
                     input logic v, input logic b, input logic d, input logic e);
    vec_t r;
    r.tag = tag;
    r.ser = ser;
    r.exp = {lout, v, b, d, e};
    q_vec.push_back(r);
  endtask

  // Start bit plus mask/lane/length fields; busy is high after each of these edges.
  task automatic add_hdr(input string tag, input logic [3:0] mask, input logic [1:0] lane,
                         input logic [3:0] len);
    logic [10:0] bits;
    bits = {1'b0, mask, lane, len};
    for (int i = 10; i >= 0; i--) add(tag, bits[i], 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic run_vec();
    for (int i = 0; i < q_vec.size(); i++) begin
      serIn = q_vec[i].ser;
      @(posedge clk);
      #1;
      check($sformatf("%s[%0d]", q_vec[i].tag, i), q_vec[i].exp);
    end
    q_vec.delete();
  endtask

  initial begin
    // T1: reset held with serIn toggling
    for (int i = 0; i < 3; i++) begin
      serIn = i[0];
      @(posedge clk);
      #1;
      check($sformatf("T1_reset[%0d]", i), 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    add("T1_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T2: mask 1010, lane 2, three payload bits 1,0,1
    add_hdr("T2", 4'b1010, 2'b10, 4'b0011);
    add("T2_d0", 1'b1, 16'h4040, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T2_d1", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T2_d2", 1'b1, 16'h4040, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T2_done", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add("T2_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T3: all ports, lane 0, one bit
    add_hdr("T3", 4'b1111, 2'b00, 4'b0001);
    add("T3_d0", 1'b1, 16'h1111, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T3_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add("T3_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T4: empty mask still consumes payload, then err with done
    add_hdr("T4", 4'b0000, 2'b01, 4'b0010);
    add("T4_d0", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T4_d1", 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T4_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1);
    add("T4_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T5: zero length goes straight to done
    add_hdr("T5", 4'b0110, 2'b11, 4'b0000);
    add("T5_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add("T5_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // T7: ports 3 and 0, lane 1 -> bits 13 and 1; starts right after DONE
    add_hdr("T7", 4'b1001, 2'b01, 4'b0010);
    add("T7_d0", 1'b1, 16'h2002, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T7_d1", 1'b1, 16'h2002, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T7_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add_hdr("T8", 4'b0001, 2'b11, 4'b0001);
    add("T8_d0", 1'b1, 16'h0008, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T8_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add("T8_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec();

    // T6: asynchronous reset during the second payload bit
    add_hdr("T6", 4'b1010, 2'b10, 4'b0011);
    add("T6_d0", 1'b1, 16'h4040, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T6_d1", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    run_vec();
    #2;
    rst = 1'b1;
    #1;
    check("T6_async_clear", 20'h0);
    for (int i = 0; i < 2; i++) begin
      serIn = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("T6_no_done[%0d]", i), 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    add_hdr("T6_re", 4'b1010, 2'b10, 4'b0011);
    add("T6_re_d0", 1'b1, 16'h4040, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T6_re_d1", 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T6_re_d2", 1'b1, 16'h4040, 1'b1, 1'b1, 1'b0, 1'b0);
    add("T6_re_done", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    add("T6_re_idle", 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    run_vec();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
